vga_tile_render: RTL
====================

VGA_TILE_RENDER -- requirements
Module: vga_tile_render

Interface
REQ-001 SHALL have parameter BLINK_LOG2, default 5, cursor blink half-period = 2^BLINK_LOG2 frames.
REQ-002 SHALL have port Clk  input  1  system clock (50 MHz); the block has one clock.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pixel_tick  input  1  pixel-rate enable from the timing generator.
REQ-005 SHALL have port video_on  input  1  visible-region flag from the timing generator.
REQ-006 SHALL have ports X, Y  input  10 each  current pixel column/row.
REQ-007 SHALL have ports Hsync_in, Vsync_in  input  1 each  sync from the timing generator, high during retrace.
REQ-008 SHALL have ports Tile_We  input  1, Tile_Addr  input  11, Tile_Data  input  8  CPU tile-RAM write port.
REQ-009 SHALL have ports Cursor_X  input  6, Cursor_Y  input  5  cursor tile coordinates.
REQ-010 SHALL have ports Red, Green, Blue  output  4 each  registered pixel colour.
REQ-011 SHALL have ports Hsync, Vsync  output  1 each  sync delayed to align with the colour outputs.

Function
REQ-012 SHALL divide the 640x480 display into 40x30 tiles of 16x16 pixels; tile index = Y[9:4]*40 + X[9:4], computed as (row<<5)+(row<<3)+col in 11 bits.
REQ-013 SHALL hold 1200x8-bit tile RAM: [7:4] foreground palette index, [3:0] pattern id.
REQ-014 SHALL write Tile_Data on Tile_We in any cycle regardless of pixel_tick; Tile_Addr >= 1200 is ignored. A read and a write to the same address in the same cycle return the old data.
REQ-015 SHALL advance a 3-stage pipeline only on cycles with pixel_tick=1:
- S1: register the tile address, X[3:0], Y[3:0], video_on, Hsync_in, Vsync_in.
- S2: synchronous RAM data is available; forward the fine coordinates and flags.
- S3: register RGB and syncs.
REQ-016 SHALL give a latency of exactly 3 pixel_ticks from input to Red/Green/Blue/Hsync/Vsync, for colour and sync alike.
REQ-017 SHALL select pattern bit = pattern[id][row Y[3:0]][15-X[3:0]], with the MSB leftmost.
REQ-018 SHALL output palette[fg] when the pattern bit is 1, and palette[0] when it is 0.
REQ-019 SHALL force RGB to 0 when the delayed video_on is 0.
REQ-020 SHALL hold all outputs stable on cycles where pixel_tick=0.

Reset
REQ-021 SHALL, on Reset=1 at a Clk edge:
- clear all pipeline registers;
- set Red/Green/Blue=0 and Hsync/Vsync=0;
- clear the frame counter, blink state and latched cursor position.
REQ-022 SHALL not clear tile RAM contents on reset.
REQ-023 SHALL let reset asserted mid-frame take effect in the same edge and override pixel_tick and Tile_We.
REQ-024 SHALL produce valid output 3 pixel_ticks after reset deasserts.

Configuration
REQ-025 SHALL compile the hardware cursor when VGA_TILE_CURSOR_EN is defined:
- On each Vsync_in rising edge, sampled on pixel_tick, latch Cursor_X/Cursor_Y and increment the frame counter.
- Blink toggles every 2^BLINK_LOG2 frames.
- While blink is on, pixels inside the latched cursor tile output the bitwise inverse of the computed RGB.
- Cursor_X >= 40 or Cursor_Y >= 30 means no cursor is drawn.
REQ-026 SHALL, without VGA_TILE_CURSOR_EN, contain no frame counter or cursor logic; Cursor_X/Cursor_Y are ignored.

Structure
REQ-027 SHALL place TILE_W=16, TILES_X=40, TILES_Y=30, TILE_COUNT=1200 and the 16x12-bit palette constant (palette[0]=12'h000) in shared package vga_render_pkg.
REQ-028 SHALL implement the pattern store in sub-module vga_pattern_rom: 16 patterns x 16 rows x 16 bits, combinational read of one row.

Verification
REQ-029 SHALL cover: write addr 0 = 8'h21 (fg 2, pattern 1 = solid) with palette[2]=12'hF00, scan X=0..15,Y=0 -> Red=4'hF, Green=Blue=0 exactly 3 pixel_ticks after each input pixel.
REQ-030 SHALL cover: write addr 1239 = 8'h31 -> ignored; addr 1199 = 8'h31 -> pixel X=639,Y=479 shows palette[3].
REQ-031 SHALL cover: video_on=0 with a solid tile -> RGB=0; Hsync_in pulse at X=656..751 -> Hsync high for the same span delayed by 3 pixel_ticks.
REQ-032 SHALL cover: Tile_We to addr 5 on the same cycle S1 reads addr 5 -> old value rendered; the next frame shows the new value.
REQ-033 SHALL cover: Reset asserted mid-line for 1 cycle -> all outputs 0 next edge; tile RAM contents are retained.
REQ-034 SHALL cover, with VGA_TILE_CURSOR_EN: Cursor=(2,1), BLINK_LOG2=1 -> the tile at X=32..47,Y=16..31 is inverted in frames 0-1, normal in frames 2-3; Cursor_X=45 -> no inversion.

Source files
------------

// File: rtl/vga_render_pkg.sv
// Shared geometry, palette and per-pixel pipeline types for the VGA tile renderer.
package vga_render_pkg;

    localparam int TILE_W     = 16;
    localparam int TILES_X    = 40;
    localparam int TILES_Y    = 30;
    localparam int TILE_COUNT = TILES_X * TILES_Y;
    localparam int TILE_AW    = 11;
    localparam int FINE_W     = $clog2(TILE_W);

    localparam logic [TILE_AW-1:0] TILE_COUNT_W = TILE_AW'(TILE_COUNT);

    // Entry 0 doubles as the background colour for every tile.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'hF80, 12'h08F, 12'h8F0,
        12'h444, 12'hCCC, 12'hF08, 12'h0F8
    };

    typedef struct packed {
        logic [FINE_W-1:0] fx;
        logic [FINE_W-1:0] fy;
        logic              von;
        logic              hs;
        logic              vs;
    } pix_flags_t;

    function automatic logic [TILE_AW-1:0] tile_index(input logic [5:0] row,
                                                      input logic [5:0] col);
        logic [TILE_AW-1:0] r;
        r = {5'b0, row};
        return (r << 5) + (r << 3) + {5'b0, col};
    endfunction

endpackage

// File: rtl/vga_pattern_rom.sv
// Pattern store: 16 glyph patterns of 16x16 bits, one row read combinationally.
module vga_pattern_rom (
    input  logic [3:0]  pattern_id_i,
    input  logic [3:0]  row_i,
    output logic [15:0] row_bits_o
);

    // Bit 15 of each row is the leftmost pixel of the tile.
    always_comb begin
        row_bits_o = 16'h0000;
        unique case (pattern_id_i)
            4'd0:  row_bits_o = 16'h0000;
            4'd1:  row_bits_o = 16'hFFFF;
            4'd2:  row_bits_o = row_i[0] ? 16'hFFFF : 16'h0000;
            4'd3:  row_bits_o = 16'hAAAA;
            4'd4:  row_bits_o = row_i[0] ? 16'h5555 : 16'hAAAA;
            4'd5:  row_bits_o = ((row_i == 4'd0) || (row_i == 4'd15)) ? 16'hFFFF : 16'h8001;
            4'd6:  row_bits_o = 16'h8000 >> row_i;
            4'd7:  row_bits_o = row_i[3] ? 16'h0000 : 16'hFFFF;
            4'd8:  row_bits_o = 16'hFF00;
            4'd9:  row_bits_o = ((row_i == 4'd7) || (row_i == 4'd8)) ? 16'hFFFF : 16'h0180;
            4'd10: row_bits_o = 16'h0001 << row_i;
            4'd11: row_bits_o = (row_i[1:0] == 2'd0) ? 16'h8888 : 16'h0000;
            4'd12: row_bits_o = row_i[2] ? 16'h0F0F : 16'hF0F0;
            4'd13: row_bits_o = row_i[3] ? 16'hFFFF : 16'h0000;
            4'd14: row_bits_o = 16'h00FF;
            4'd15: row_bits_o = row_i[0] ? 16'hAAAA : 16'h5555;
            default: row_bits_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/vga_tile_render.sv
// 40x30 tile renderer with a 3-stage pixel_tick pipeline from X/Y to registered RGB and syncs.
// Define VGA_TILE_CURSOR_EN to build the blinking hardware cursor.
module vga_tile_render
    import vga_render_pkg::*;
#(
    parameter int BLINK_LOG2 = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        Hsync_in,
    input  logic        Vsync_in,
    input  logic        Tile_We,
    input  logic [10:0] Tile_Addr,
    input  logic [7:0]  Tile_Data,
    input  logic [5:0]  Cursor_X,
    input  logic [4:0]  Cursor_Y,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        Hsync,
    output logic        Vsync
);

    logic [7:0]         tile_ram [TILE_COUNT];

    logic [TILE_AW-1:0] tile_addr_d;
    pix_flags_t         s1_flags_d;
    logic [TILE_AW-1:0] s1_addr_q;
    pix_flags_t         s1_flags_q;
    logic [7:0]         s2_tile_q;
    pix_flags_t         s2_flags_q;
    logic [11:0]        rgb_d;
    logic [11:0]        rgb_q;
    logic               hs_q;
    logic               vs_q;
    logic [15:0]        row_bits;
    logic               pix_on;

    // Reset blocks writes but leaves the contents alone.
    always_ff @(posedge Clk) begin
        if (!Reset && Tile_We && (Tile_Addr < TILE_COUNT_W)) begin
            tile_ram[Tile_Addr] <= Tile_Data;
        end
    end

    always_comb begin
        tile_addr_d    = tile_index(Y[9:FINE_W], X[9:FINE_W]);
        s1_flags_d     = '0;
        s1_flags_d.fx  = X[FINE_W-1:0];
        s1_flags_d.fy  = Y[FINE_W-1:0];
        s1_flags_d.von = video_on;
        s1_flags_d.hs  = Hsync_in;
        s1_flags_d.vs  = Vsync_in;
    end

    // Off-screen addresses read as tile 0x00 so blanking pixels never index past the RAM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_addr_q  <= '0;
            s1_flags_q <= '0;
            s2_tile_q  <= '0;
            s2_flags_q <= '0;
            rgb_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else if (pixel_tick) begin
            s1_addr_q  <= tile_addr_d;
            s1_flags_q <= s1_flags_d;
            s2_tile_q  <= (s1_addr_q < TILE_COUNT_W) ? tile_ram[s1_addr_q] : 8'h00;
            s2_flags_q <= s1_flags_q;
            rgb_q      <= rgb_d;
            hs_q       <= s2_flags_q.hs;
            vs_q       <= s2_flags_q.vs;
        end
    end

    vga_pattern_rom u_pattern_rom (
        .pattern_id_i (s2_tile_q[3:0]),
        .row_i        (s2_flags_q.fy),
        .row_bits_o   (row_bits)
    );

    assign pix_on = row_bits[~s2_flags_q.fx];

`ifdef VGA_TILE_CURSOR_EN
    logic [5:0]            cur_x_q;
    logic [4:0]            cur_y_q;
    logic [BLINK_LOG2-1:0] frame_cnt_q;
    logic                  cur_hide_q;
    logic                  s1_cur_q;
    logic                  s2_cur_q;
    logic                  cur_hit_d;
    logic                  vs_rise;

    // s1_flags_q.vs holds Vsync_in from the previous pixel, so this is a tick-sampled edge.
    assign vs_rise   = Vsync_in && !s1_flags_q.vs;
    assign cur_hit_d = (cur_x_q < 6'(TILES_X)) && (cur_y_q < 5'(TILES_Y))
                    && (X[9:FINE_W] == cur_x_q) && (Y[9:FINE_W] == {1'b0, cur_y_q});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            frame_cnt_q <= '0;
            cur_hide_q  <= 1'b0;
            s1_cur_q    <= 1'b0;
            s2_cur_q    <= 1'b0;
        end else if (pixel_tick) begin
            s1_cur_q <= cur_hit_d;
            s2_cur_q <= s1_cur_q;
            if (vs_rise) begin
                cur_x_q     <= Cursor_X;
                cur_y_q     <= Cursor_Y;
                frame_cnt_q <= frame_cnt_q + BLINK_LOG2'(1);
                if (&frame_cnt_q) begin
                    cur_hide_q <= ~cur_hide_q;
                end
            end
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{Cursor_X, Cursor_Y, BLINK_LOG2[0]};
`endif

    always_comb begin
        rgb_d = pix_on ? PALETTE[s2_tile_q[7:4]] : PALETTE[0];
`ifdef VGA_TILE_CURSOR_EN
        if (s2_cur_q && !cur_hide_q) begin
            rgb_d = ~rgb_d;
        end
`endif
        if (!s2_flags_q.von) begin
            rgb_d = '0;
        end
    end

    assign Red   = rgb_q[11:8];
    assign Green = rgb_q[7:4];
    assign Blue  = rgb_q[3:0];
    assign Hsync = hs_q;
    assign Vsync = vs_q;

endmodule
